apb_master_bridge: RTL and testbench

- Converts a simple single-outstanding req/gnt/rvalid core-side interface into 64-bit APB master transfers.
- Lets a core, debug module or DMA reach memory-mapped APB slaves such as the machine timer (mtime/mtimecmp) in the SoC peripheral region.
- Adds a PREADY timeout and a misalignment check so a hung or misaddressed slave never blocks the requester.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_master_bridge.sv | 138 +++++++++++++
 tb/tb_apb_master_bridge.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types for the core-side to APB master bridge: FSM states, the
// response payload and the fixed APB data width.
package apb_pkg;

    localparam int APB_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding req/gnt/rvalid to 64-bit APB master bridge with a
// PREADY timeout and an 8-byte alignment check.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    apb_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      rvalid_q, rvalid_d;
    apb_rsp_t                  rsp_q, rsp_d;
    logic                      err_pend_q, err_pend_d;

    logic in_access;
    logic timeout_hit;
    logic complete;
    logic accept;
    logic misaligned;
    logic mis_acc;

    assign in_access   = (state_q == ACCESS);
    assign timeout_hit = TIMEOUT_EN && in_access && (cnt_q == CNT_LAST) && !PREADY;
    assign complete    = in_access && (PREADY || timeout_hit);
    assign gnt_o       = (state_q == IDLE) || complete;
    assign accept      = req_i && gnt_o;
    assign misaligned  = (addr_i[2:0] != 3'b000);
    assign mis_acc     = accept && misaligned;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        rvalid_d   = 1'b0;
        rsp_d      = '0;
        err_pend_d = 1'b0;

        case (state_q)
            IDLE: state_d = IDLE;
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (complete) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            paddr_d  = addr_i;
            pwrite_d = we_i;
            pwdata_d = wdata_i;
            state_d  = misaligned ? IDLE : SETUP;
        end

        // A misaligned accept that coincides with a bus completion (or with a
        // still-pending misaligned error) is deferred one cycle to keep order.
        rvalid_d = complete || err_pend_q || mis_acc;
        if (complete) begin
            rsp_d.err   = timeout_hit ? 1'b1 : PSLVERR;
            rsp_d.rdata = (pwrite_q || timeout_hit) ? '0 : PRDATA;
            err_pend_d  = mis_acc;
        end else if (err_pend_q) begin
            rsp_d.err   = 1'b1;
            err_pend_d  = mis_acc;
        end else if (mis_acc) begin
            rsp_d.err   = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rsp_q      <= '0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            rvalid_q   <= rvalid_d;
            rsp_q      <= rsp_d;
            err_pend_q <= err_pend_d;
        end
    end

    assign PSEL     = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE  = (state_q == ACCESS);
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign PWRITE   = pwrite_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rsp_q.rdata;
    assign err_o    = rsp_q.err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a default-timeout instance for the
// transfer tests and a TIMEOUT_CYCLES=4 instance for the timeout test.
module tb_apb_master_bridge;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req, req_t, we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] PRDATA;
    logic        PREADY, PSLVERR;

    logic        gnt, rvalid, err, PWRITE, PSEL, PENABLE;
    logic [63:0] rdata, PWDATA;
    logic [11:0] PADDR;

    logic        gnt_t, rvalid_t, err_t, PWRITE_t, PSEL_t, PENABLE_t;
    logic [63:0] rdata_t, PWDATA_t;
    logic [11:0] PADDR_t;

    int n_cmp = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    apb_master_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(255)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_master_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) u_dut_to (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_i(req_t), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt_t), .rvalid_o(rvalid_t), .rdata_o(rdata_t), .err_o(err_t),
        .PADDR(PADDR_t), .PWDATA(PWDATA_t), .PWRITE(PWRITE_t),
        .PSEL(PSEL_t), .PENABLE(PENABLE_t),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        int          pe;
        int          rvc;
        logic [8:0]  acc_v, rv_v, ps_v;

        HRESETn = 1'b0; req = 1'b0; req_t = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        // reset state
        repeat (3) cyc();
        #1;
        chk("rst_psel",    64'(PSEL),    64'd0);
        chk("rst_penable", 64'(PENABLE), 64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        chk("rst_rdata",   rdata,        64'd0);
        chk("rst_err",     64'(err),     64'd0);
        chk("rst_paddr",   64'(PADDR),   64'd0);
        chk("rst_pwdata",  PWDATA,       64'd0);
        chk("rst_gnt",     64'(gnt),     64'd1);
        cyc();
        HRESETn = 1'b1;

        // zero-wait write
        cyc();
        req = 1'b1; we = 1'b1; addr = 12'h008; wdata = 64'hDEAD_BEEF_0000_0001;
        #1 chk("wr_gnt", 64'(gnt), 64'd1);
        cyc();
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; PREADY = 1'b1;
        #1;
        chk("wr_setup_psel",    64'(PSEL),    64'd1);
        chk("wr_setup_penable", 64'(PENABLE), 64'd0);
        chk("wr_setup_paddr",   64'(PADDR),   64'h008);
        chk("wr_setup_pwdata",  PWDATA,       64'hDEAD_BEEF_0000_0001);
        chk("wr_setup_pwrite",  64'(PWRITE),  64'd1);
        chk("wr_setup_gnt",     64'(gnt),     64'd0);
        cyc();
        #1;
        chk("wr_access_penable", 64'(PENABLE), 64'd1);
        chk("wr_access_paddr",   64'(PADDR),   64'h008);
        chk("wr_access_pwdata",  PWDATA,       64'hDEAD_BEEF_0000_0001);
        chk("wr_access_gnt",     64'(gnt),     64'd1);
        cyc();
        PREADY = 1'b0;
        #1;
        chk("wr_rvalid", 64'(rvalid), 64'd1);
        chk("wr_err",    64'(err),    64'd0);
        chk("wr_rdata",  rdata,       64'd0);
        chk("wr_psel",   64'(PSEL),   64'd0);
        cyc();
        #1 chk("wr_rvalid_pulse", 64'(rvalid), 64'd0);

        // read with 4 wait states
        cyc();
        req = 1'b1; we = 1'b0; addr = 12'h000; PRDATA = 64'h0000_0000_0001_2345;
        #1;
        cyc();
        req = 1'b0;
        #1;
        pe = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 4) PREADY = 1'b1;
            #1;
            if (PENABLE) pe++;
            if (i == 0) chk("rd_wait_gnt", 64'(gnt), 64'd0);
        end
        chk("rd_penable_cycles", 64'(pe), 64'd5);
        cyc();
        PREADY = 1'b0;
        #1;
        chk("rd_rvalid",  64'(rvalid),  64'd1);
        chk("rd_rdata",   rdata,        64'h12345);
        chk("rd_err",     64'(err),     64'd0);
        chk("rd_penable", 64'(PENABLE), 64'd0);

        // back-to-back writes with PREADY tied high
        PREADY = 1'b1;
        acc_v = '0; rv_v = '0; ps_v = '0;
        for (int c = 0; c < 9; c++) begin
            cyc();
            if (c == 0) begin req = 1'b1; we = 1'b1; addr = 12'h010; wdata = 64'hA; end
            if (c == 1) begin addr = 12'h018; wdata = 64'hB; end
            if (c == 3) begin addr = 12'h020; wdata = 64'hC; end
            if (c == 5) req = 1'b0;
            #1;
            acc_v[c] = req & gnt;
            rv_v[c]  = rvalid;
            ps_v[c]  = PSEL;
            if (c == 5) begin
                chk("b2b_paddr3",  64'(PADDR), 64'h020);
                chk("b2b_pwdata3", PWDATA,     64'hC);
            end
            if (c == 7) chk("b2b_rdata3", rdata, 64'd0);
        end
        PREADY = 1'b0;
        chk("b2b_accept_cycles", 64'(acc_v), 64'(9'b000010101));
        chk("b2b_rvalid_cycles", 64'(rv_v),  64'(9'b010101000));
        chk("b2b_psel_cycles",   64'(ps_v),  64'(9'b001111110));

        // read with slave error
        cyc();
        req = 1'b1; we = 1'b0; addr = 12'h030;
        PRDATA = 64'hCAFE_F00D_1234_5678; PREADY = 1'b1; PSLVERR = 1'b1;
        #1;
        cyc();
        req = 1'b0;
        #1;
        cyc();
        #1;
        cyc();
        #1;
        chk("slverr_rvalid", 64'(rvalid), 64'd1);
        chk("slverr_err",    64'(err),    64'd1);
        chk("slverr_rdata",  rdata,       64'hCAFE_F00D_1234_5678);
        PREADY = 1'b0; PSLVERR = 1'b0;

        // misaligned access
        cyc();
        req = 1'b1; we = 1'b1; addr = 12'h004; wdata = 64'h55;
        #1 chk("mis_gnt", 64'(gnt), 64'd1);
        cyc();
        req = 1'b0;
        #1;
        chk("mis_psel",   64'(PSEL),   64'd0);
        chk("mis_rvalid", 64'(rvalid), 64'd1);
        chk("mis_err",    64'(err),    64'd1);
        chk("mis_rdata",  rdata,       64'd0);
        cyc();
        #1;
        chk("mis_rvalid_pulse", 64'(rvalid), 64'd0);
        chk("mis_psel_after",   64'(PSEL),   64'd0);

        // timeout on the TIMEOUT_CYCLES=4 instance
        cyc();
        req_t = 1'b1; we = 1'b0; addr = 12'h040; PRDATA = 64'hFFFF;
        #1 chk("to_gnt", 64'(gnt_t), 64'd1);
        cyc();
        req_t = 1'b0;
        #1;
        pe = 0; rvc = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            if (PENABLE_t) pe++;
            if (rvalid_t) rvc++;
            if (i == 4) begin
                chk("to_rvalid", 64'(rvalid_t), 64'd1);
                chk("to_err",    64'(err_t),    64'd1);
                chk("to_rdata",  rdata_t,       64'd0);
                chk("to_psel",   64'(PSEL_t),   64'd0);
            end
        end
        chk("to_access_cycles", 64'(pe),  64'd4);
        chk("to_rvalid_count",  64'(rvc), 64'd1);
        cyc();
        PREADY = 1'b1;
        #1 chk("to_late_a", 64'(rvalid_t), 64'd0);
        cyc();
        PREADY = 1'b0;
        #1 chk("to_late_b", 64'(rvalid_t), 64'd0);
        cyc();
        #1 chk("to_late_c", 64'(rvalid_t), 64'd0);

        // reset during ACCESS, then a fresh read
        cyc();
        req = 1'b1; we = 1'b0; addr = 12'h050;
        #1;
        cyc();
        req = 1'b0;
        #1;
        cyc();
        #1 chk("rstx_in_access", 64'(PENABLE), 64'd1);
        HRESETn = 1'b0;
        #1;
        chk("rstx_psel",    64'(PSEL),    64'd0);
        chk("rstx_penable", 64'(PENABLE), 64'd0);
        chk("rstx_rvalid",  64'(rvalid),  64'd0);
        chk("rstx_idle",    64'(gnt),     64'd1);
        cyc();
        cyc();
        HRESETn = 1'b1;
        #1 chk("rstx_no_rsp", 64'(rvalid), 64'd0);
        cyc();
        req = 1'b1; we = 1'b0; addr = 12'h058;
        PRDATA = 64'h0123_4567_89AB_CDEF; PREADY = 1'b1;
        #1;
        cyc();
        req = 1'b0;
        #1;
        cyc();
        #1;
        cyc();
        #1;
        chk("rstx_rd_rvalid", 64'(rvalid), 64'd1);
        chk("rstx_rd_rdata",  rdata,       64'h0123_4567_89AB_CDEF);
        chk("rstx_rd_err",    64'(err),    64'd0);
        PREADY = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
